// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub: WIDTH-bit adder/subtractor cut into CHUNK-bit slices,
// with one slice per pipeline stage and the carry registered between stages.
// Each stage register holds three things. The first is the operand slices
// that are still to be added, right-aligned so that the next stage always
// takes bits [CHUNK-1:0]. The second is the result slices finished so far,
// shifted in from the top so that slice 0 lands at bit 0 after the last stage.
// The third is the carry and the operand sign bits used for the overflow flag.
// The whole chain stalls globally whenever the output is held.
module pipelined_adder_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic             adv;
    logic [WIDTH-1:0] b_eff;

    // Stage inputs: the ports for stage 0, the previous stage register otherwise
    logic [WIDTH-1:0] a_in  [STAGES];
    logic [WIDTH-1:0] b_in  [STAGES];
    logic [WIDTH-1:0] r_in  [STAGES];
    logic             c_in  [STAGES];
    logic             v_in  [STAGES];
    logic             am_in [STAGES];
    logic             bm_in [STAGES];

    // Stage registers and their next-state values
    logic [WIDTH-1:0] a_d  [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_d  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] r_d  [STAGES];
    logic [WIDTH-1:0] r_q  [STAGES];
    logic             c_d  [STAGES];
    logic             c_q  [STAGES];
    logic             v_d  [STAGES];
    logic             v_q  [STAGES];
    logic             am_d [STAGES];
    logic             am_q [STAGES];
    logic             bm_d [STAGES];
    logic             bm_q [STAGES];

    // Global stall control and the subtract conditioning of operand B and the carry
    always_comb begin
        adv   = !v_q[LAST] || out_ready;
        b_eff = sub ? ~b : b;
    end

    // Wire each stage to its source: the conditioned operands for stage 0, the previous stage otherwise
    always_comb begin
        a_in[0]  = a;
        b_in[0]  = b_eff;
        r_in[0]  = '0;
        c_in[0]  = sub ^ cin;
        v_in[0]  = in_valid;
        am_in[0] = a[WIDTH-1];
        bm_in[0] = b_eff[WIDTH-1];
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]  = a_q[k-1];
            b_in[k]  = b_q[k-1];
            r_in[k]  = r_q[k-1];
            c_in[k]  = c_q[k-1];
            v_in[k]  = v_q[k-1];
            am_in[k] = am_q[k-1];
            bm_in[k] = bm_q[k-1];
        end
    end

    // Per-stage slice addition; data loads only when a valid op moves in, so outputs hold across bubbles
    always_comb begin : stage_calc
        logic [CHUNK:0] tot;
        tot = '0;
        for (int k = 0; k < STAGES; k++) begin
            tot = {1'b0, a_in[k][CHUNK-1:0]} + {1'b0, b_in[k][CHUNK-1:0]}
                + {{CHUNK{1'b0}}, c_in[k]};
            if (adv && v_in[k]) begin
                a_d[k]  = a_in[k] >> CHUNK;
                b_d[k]  = b_in[k] >> CHUNK;
                r_d[k]  = (r_in[k] >> CHUNK) | (WIDTH'(tot[CHUNK-1:0]) << (WIDTH - CHUNK));
                c_d[k]  = tot[CHUNK];
                am_d[k] = am_in[k];
                bm_d[k] = bm_in[k];
            end else begin
                a_d[k]  = a_q[k];
                b_d[k]  = b_q[k];
                r_d[k]  = r_q[k];
                c_d[k]  = c_q[k];
                am_d[k] = am_q[k];
                bm_d[k] = bm_q[k];
            end
            v_d[k] = adv ? v_in[k] : v_q[k];
        end
    end

    // Stage registers; reset clears every valid bit and all stored data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                r_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                v_q[k]  <= 1'b0;
                am_q[k] <= 1'b0;
                bm_q[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= a_d[k];
                b_q[k]  <= b_d[k];
                r_q[k]  <= r_d[k];
                c_q[k]  <= c_d[k];
                v_q[k]  <= v_d[k];
                am_q[k] <= am_d[k];
                bm_q[k] <= bm_d[k];
            end
        end
    end

    // Outputs come straight from the last stage register
    always_comb begin
        in_ready  = adv;
        out_valid = v_q[LAST];
        s         = r_q[LAST];
        cout      = c_q[LAST];
        ovf       = (am_q[LAST] == bm_q[LAST]) && (r_q[LAST][WIDTH-1] != am_q[LAST]);
    end

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: directed vectors, a random stream with
// backpressure, a mid-stream reset, and an exhaustive WIDTH=CHUNK=4 instance.
module tb_pipelined_adder_sub;

    localparam int W = 16;
    localparam int C = 4;
    localparam int S = W / C;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, s;
    logic         in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4;
    logic [3:0]   a4, b4, s4;

    int n_cmp = 0;
    int n_bad = 0;

    pipelined_adder_sub #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
    );

    pipelined_adder_sub #(.WIDTH(4), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out_valid4),
        .out_ready(out_ready4), .s(s4), .cout(cout4), .ovf(ovf4)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           cyc;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands
    function automatic void model(input int w, input longint av, input longint bv,
                                  input bit ci, input bit sb,
                                  output longint sv, output bit co, output bit ov);
        longint full, half, c, t, sa, sbv, st;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        c    = ci ? 1 : 0;
        t    = sb ? av - bv - c : av + bv + c;
        co   = sb ? (t >= 0) : (t >= full);
        sv   = t & (full - 1);
        sa   = (av >= half) ? av - full : av;
        sbv  = (bv >= half) ? bv - full : bv;
        st   = sb ? sa - sbv - c : sa + sbv + c;
        ov   = (st >= half) || (st < -half);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (S + 1) tick();
    endtask

    // One operation in isolation; returns the result and the cycles from accept to out_valid
    task automatic run_single(input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic tc, input logic ts,
                              output logic [W-1:0] rs, output logic rc, output logic ro,
                              output int lat);
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("single_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        rs = s; rc = cout; ro = ovf;
    endtask

    vec_t         vecs [6];
    exp_t         q16 [$];
    exp_t         q4 [$];
    exp_t         e;
    logic [W-1:0] rs, ha, hb, hs;
    logic         rc, ro, hc, ho, held;
    int           lat, nxt, got, last_cyc, seen;
    longint       sv;
    bit           co, ov;
    logic [W-1:0] ra [20];
    logic [W-1:0] rb [20];
    logic         rci [20];
    logic         rsb [20];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};

        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;

        // Reset held for three cycles with in_valid asserted
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0;
        repeat (3) tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_s", s, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", ovf, 0);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1);

        // Directed vectors: value and no-stall latency
        for (int i = 0; i < 6; i++) begin
            run_single(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
            $display("vec %0d: a=%h b=%h cin=%0d sub=%0d -> s=%h cout=%0d ovf=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
            chk($sformatf("vec%0d_s", i), rs, vecs[i].es);
            chk($sformatf("vec%0d_cout", i), rc, vecs[i].ec);
            chk($sformatf("vec%0d_ovf", i), ro, vecs[i].eo);
            chk($sformatf("vec%0d_latency", i), lat, S);
        end
        drain();

        // Random back-to-back stream with out_ready low for cycles 6..9
        for (int i = 0; i < 20; i++) begin
            ra[i] = W'($urandom); rb[i] = W'($urandom);
            rci[i] = 1'($urandom); rsb[i] = 1'($urandom);
        end
        nxt = 0; got = 0; last_cyc = -1; held = 1'b0; hs = '0; hc = 1'b0; ho = 1'b0;
        for (int c = 0; c < 60 && got < 20; c++) begin
            out_ready = !(c >= 6 && c <= 9);
            if (held)
                chk("stall_hold", {out_valid, s, cout, ovf}, {1'b1, hs, hc, ho});
            if (out_valid && out_ready) begin
                if (q16.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stream_extra: got s=%h with no result outstanding, expected none", s);
                end else begin
                    e = q16.pop_front();
                    $display("stream out %0d @%0d: s=%h cout=%0d ovf=%0d exp s=%h cout=%0d ovf=%0d",
                             got, c, s, cout, ovf, e.s, e.c, e.o);
                    chk("stream_result", {s, cout, ovf}, {e.s, e.c, e.o});
                end
                got++;
                last_cyc = c;
            end
            held = out_valid && !out_ready;
            hs = s; hc = cout; ho = ovf;
            if (nxt < 20) begin
                in_valid = 1'b1; a = ra[nxt]; b = rb[nxt]; cin = rci[nxt]; sub = rsb[nxt];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 6 && c <= 9)
                chk("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) begin
                model(W, longint'(a), longint'(b), cin, sub, sv, co, ov);
                e.s = sv[W-1:0]; e.c = co; e.o = ov; e.cyc = c;
                q16.push_back(e);
                nxt++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("stream_count", got, 20);
        chk("stream_last_cycle", last_cyc, 27);
        chk("stream_leftover", q16.size(), 0);
        drain();

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            cin = 1'($urandom); sub = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            if (out_valid) seen++;
            tick();
        end
        $display("flush: out_valid cycles after mid-stream reset = %0d", seen);
        chk("flush_no_output", seen, 0);
        ha = W'($urandom); hb = W'($urandom);
        model(W, longint'(ha), longint'(hb), 1'b1, 1'b1, sv, co, ov);
        run_single(ha, hb, 1'b1, 1'b1, rs, rc, ro, lat);
        $display("post-reset op: a=%h b=%h -> s=%h cout=%0d ovf=%0d lat=%0d", ha, hb, rs, rc, ro, lat);
        chk("post_reset_result", {rs, rc, ro}, {sv[W-1:0], co, ov});
        chk("post_reset_latency", lat, S);
        drain();

        // Exhaustive 4-bit single-stage instance, streamed at full rate
        nxt = 0; got = 0;
        for (int c = 0; c < 1100 && got < 1024; c++) begin
            if (out_valid4) begin
                if (q4.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL exh_extra: got s=%h with no result outstanding, expected none", s4);
                end else begin
                    e = q4.pop_front();
                    chk($sformatf("exh%0d_result", got), {s4, cout4, ovf4}, {e.s[3:0], e.c, e.o});
                    chk($sformatf("exh%0d_latency", got), c - e.cyc, 1);
                end
                got++;
            end
            if (nxt < 1024) begin
                in_valid4 = 1'b1;
                a4 = nxt[3:0]; b4 = nxt[7:4]; cin4 = nxt[8]; sub4 = nxt[9];
            end else begin
                in_valid4 = 1'b0;
            end
            #1;
            if (in_valid4 && in_ready4) begin
                model(4, longint'(a4), longint'(b4), cin4, sub4, sv, co, ov);
                e.s = W'(sv[3:0]); e.c = co; e.o = ov; e.cyc = c;
                q4.push_back(e);
                nxt++;
            end
            tick();
        end
        in_valid4 = 1'b0;
        $display("exhaustive 4-bit: %0d results received", got);
        chk("exh_count", got, 1024);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
